// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle magnitude comparator: walks two operands most-significant chunk first,
// CHUNK bits per clock, and stops at the first differing chunk (signed or unsigned).
module seq_magnitude_comparator #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8,
  localparam int NCHUNK = WIDTH / CHUNK,
  localparam int CW = $clog2(NCHUNK) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             eq,
  output logic             lt,
  output logic [CW-1:0]    cycles
);

  localparam int IW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPARE = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             sgn_q, sgn_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             gt_q, gt_d, eq_q, eq_d, lt_q, lt_d;
  logic [CW-1:0]    cyc_q, cyc_d;
  logic             busy_q, busy_d, done_q, done_d;

  logic [CHUNK-1:0] a_chunk_s, b_chunk_s;
  logic             top_s, chunk_gt_s, chunk_lt_s;
  logic [CW-1:0]    cnt_inc_s;

  assign a_chunk_s = a_q[idx_q*CHUNK +: CHUNK];
  assign b_chunk_s = b_q[idx_q*CHUNK +: CHUNK];
  assign top_s     = (idx_q == IW'(NCHUNK - 1));
  assign cnt_inc_s = cnt_q + CW'(1);

  // Chunk comparison; only the top chunk in signed mode looks at the sign bits.
  always_comb begin
    chunk_gt_s = 1'b0;
    chunk_lt_s = 1'b0;
    if (top_s && sgn_q && (a_chunk_s[CHUNK-1] != b_chunk_s[CHUNK-1])) begin
      chunk_gt_s = ~a_chunk_s[CHUNK-1];
      chunk_lt_s = a_chunk_s[CHUNK-1];
    end else begin
      chunk_gt_s = (a_chunk_s > b_chunk_s);
      chunk_lt_s = (a_chunk_s < b_chunk_s);
    end
  end

  // Next-state and next-output logic for the IDLE/COMPARE/DONE sequencer.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sgn_d   = sgn_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    gt_d    = gt_q;
    eq_d    = eq_q;
    lt_d    = lt_q;
    cyc_d   = cyc_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          sgn_d   = is_signed;
          idx_d   = IW'(NCHUNK - 1);
          cnt_d   = '0;
          gt_d    = 1'b0;
          eq_d    = 1'b0;
          lt_d    = 1'b0;
          cyc_d   = '0;
          state_d = S_COMPARE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_COMPARE: begin
        cnt_d = cnt_inc_s;
        if (chunk_gt_s || chunk_lt_s) begin
          gt_d    = chunk_gt_s;
          lt_d    = chunk_lt_s;
          cyc_d   = cnt_inc_s;
          state_d = S_DONE;
        end else if (idx_q == '0) begin
          eq_d    = 1'b1;
          cyc_d   = CW'(NCHUNK);
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q - IW'(1);
          state_d = S_COMPARE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // State, operand and result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      idx_q   <= '0;
      cnt_q   <= '0;
      gt_q    <= 1'b0;
      eq_q    <= 1'b0;
      lt_q    <= 1'b0;
      cyc_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      gt_q    <= gt_d;
      eq_q    <= eq_d;
      lt_q    <= lt_d;
      cyc_q   <= cyc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign gt     = gt_q;
  assign eq     = eq_q;
  assign lt     = lt_q;
  assign cycles = cyc_q;

endmodule
